// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, two-entry skid buffer,
// stall/flush control and a saturating bubble counter.
module if_id_skid_reg #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               stall,
  input  logic               flush,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  state_e             state_q;
  logic [INSTR_W-1:0] main_instr_q, skid_instr_q;
  logic [PC_W-1:0]    main_pc_q, skid_pc_q;
  logic [CNT_W-1:0]   bubble_cnt_q;
  logic               adv, take;

  // in_ready depends only on registered state and flush, never on out_ready
  assign out_valid  = (state_q != StEmpty);
  assign in_ready   = (state_q != StFull) & ~flush;
  assign adv        = out_valid & out_ready & ~stall;
  assign take       = in_valid & in_ready;
  assign out_instr  = main_instr_q;
  assign out_pc     = main_pc_q;
  assign bubble_cnt = bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else if (flush) begin
      // squash both entries into NOP bubbles
      state_q      <= StEmpty;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (take) begin
            state_q      <= StOne;
            main_instr_q <= in_instr;
            main_pc_q    <= in_pc;
          end
        end
        StOne: begin
          if (take && adv) begin
            main_instr_q <= in_instr;
            main_pc_q    <= in_pc;
          end else if (take) begin
            state_q      <= StFull;
            skid_instr_q <= in_instr;
            skid_pc_q    <= in_pc;
          end else if (adv) begin
            state_q      <= StEmpty;
            main_instr_q <= '0;
            main_pc_q    <= '0;
          end
        end
        StFull: begin
          if (adv) begin
            state_q      <= StOne;
            main_instr_q <= skid_instr_q;
            main_pc_q    <= skid_pc_q;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

  // counts edges seen with no valid payload; saturates instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg (CNT_W=4 to reach saturation).
module tb_if_id_skid_reg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 4;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               stall;
  logic               flush;
  logic [CNT_W-1:0]   bubble_cnt;

  int tests;
  int failed;

  if_id_skid_reg #(
    .INSTR_W(INSTR_W),
    .PC_W   (PC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .stall     (stall),
    .flush     (flush),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one active edge, then settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // streaming: each pc appears one cycle after it is presented
    out_ready = 1'b1;
    present(32'h00);
    step();
    check("stream_valid_0", out_valid, 1);
    check("stream_pc_0", out_pc, 32'h00);
    check("stream_instr_0", out_instr, instr_of(32'h00));
    check("stream_ready_0", in_ready, 1);
    check("stream_bubble_first", bubble_cnt, 1);
    for (int i = 1; i < 4; i++) begin
      present(32'(i * 4));
      step();
      check("stream_pc", out_pc, 64'(i * 4));
      check("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_pc", out_pc, 0);
    check("stream_bubble_hold", bubble_cnt, 1);

    // skid fill
    out_ready = 1'b0;
    present(32'h10);
    step();
    check("skid_one_pc", out_pc, 32'h10);
    check("skid_bubble", bubble_cnt, 2);
    present(32'h14);
    step();
    check("skid_full_ready", in_ready, 0);
    check("skid_full_pc", out_pc, 32'h10);
    check("skid_full_valid", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("skid_drain_pc", out_pc, 32'h14);
    check("skid_drain_instr", out_instr, instr_of(32'h14));
    check("skid_drain_ready", in_ready, 1);
    step();
    check("skid_empty_valid", out_valid, 0);

    // stall while full
    out_ready = 1'b0;
    present(32'h30);
    step();
    present(32'h34);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stall     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", out_pc, 32'h30);
      check("stall_instr", out_instr, instr_of(32'h30));
      check("stall_ready", in_ready, 0);
    end
    stall = 1'b0;
    step();
    check("stall_drain_pc", out_pc, 32'h34);
    step();
    check("stall_empty_valid", out_valid, 0);
    check("stall_bubble", bubble_cnt, 3);

    // flush while full, with stall and out_ready also high
    out_ready = 1'b0;
    present(32'h20);
    step();
    present(32'h24);
    step();
    check("flush_pre_pc", out_pc, 32'h20);
    present(32'h28);
    flush     = 1'b1;
    stall     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush_cycle_ready", in_ready, 0);
    step();
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_valid", out_valid, 0);
    check("flush_instr", out_instr, 0);
    check("flush_pc", out_pc, 0);
    check("flush_ready", in_ready, 1);
    check("flush_bubble_edge", bubble_cnt, 4);
    step();
    check("flush_no_accept", out_valid, 0);
    check("flush_bubble_after", bubble_cnt, 5);

    // async reset between edges while full
    out_ready = 1'b0;
    present(32'h40);
    step();
    present(32'h44);
    step();
    in_valid = 1'b0;
    check("areset_pre_ready", in_ready, 0);
    check("areset_pre_bubble", bubble_cnt, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", out_valid, 0);
    check("areset_pc", out_pc, 0);
    check("areset_instr", out_instr, 0);
    check("areset_bubble", bubble_cnt, 0);
    check("areset_ready", in_ready, 1);
    rst_n = 1'b1;

    // saturation: idle edges only
    for (int i = 0; i < 15; i++) step();
    check("sat_reach", bubble_cnt, 15);
    check("sat_skid_lost", out_valid, 0);
    for (int i = 0; i < 5; i++) step();
    check("sat_hold", bubble_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
